rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource (e.g. an fsm-style engine) among
//   N requesters. Two-state controller (IDLE/GRANT): picks one requester, holds
//   a one-hot grant until the owner releases, then rotates priority. Sits between

---
 rtl/rr_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant held until release, then priority rotates past the owner.
// Optional forced release after TIMEOUT grant cycles when RR_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner; next edge grants the first requester after ptr
// GRANT | gnt/gnt_id hold the owner until rel (or timeout)
module rr_arbiter #(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  input  logic           rel,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           tmo
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] winner;
  logic           found;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // First requester strictly after ptr, wrapping; ptr itself is searched last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = wrap_add(ptr, k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          tmo_q, tmo_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 2);
`endif

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    ptr_nxt    = ptr;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_nxt    = cnt;
    tmo_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = GRANT;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          gnt_id_nxt      = winner;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_nxt         = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = gnt_id;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = gnt_id;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= IDW'(N - 1);
`ifdef RR_ARB_TIMEOUT_EN
      cnt    <= '0;
      tmo_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= gnt_id_nxt;
      ptr    <= ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      cnt    <= cnt_nxt;
      tmo_q  <= tmo_nxt;
`endif
    end
  end

  assign busy = (state == GRANT);

`ifdef RR_ARB_TIMEOUT_EN
  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed vectors with literal expectations, plus an
// owner/last-winner reference model compared against the outputs every cycle.
module tb_rr_arbiter;
  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int IDW = 2;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic           rel;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           tmo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: current owner (-1 = none), last winner, cycles granted so far
  int m_owner;
  int m_last;
  int m_len;
  bit m_tmo;

  rr_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .rel(rel),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] r, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_owner <= -1;
      m_last  <= N - 1;
      m_len   <= 0;
      m_tmo   <= 1'b0;
    end else if (m_owner < 0) begin
      m_owner <= first_req(req, m_last);
      m_len   <= 1;
      m_tmo   <= 1'b0;
    end else if (rel) begin
      m_last  <= m_owner;
      m_owner <= -1;
      m_tmo   <= 1'b0;
    end else if (TMO_EN && m_len == TO) begin
      m_last  <= m_owner;
      m_owner <= -1;
      m_tmo   <= 1'b1;
    end else begin
      m_len   <= m_len + 1;
      m_tmo   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] exp_gnt;
      exp_gnt = '0;
      if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
      check("model_gnt", 32'(gnt), 32'(exp_gnt));
      check("model_busy", 32'(busy), 32'(m_owner >= 0));
      check("model_tmo", 32'(tmo), 32'(m_tmo));
      if (m_owner >= 0) check("model_gnt_id", 32'(gnt_id), 32'(m_owner));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;

    // reset with all requesting
    rstn = 1'b0; req = 4'b1111; rel = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tmo", 32'(tmo), 32'h0);
    rstn = 1'b1;
    tick();
    check("first_gnt", 32'(gnt), 32'b0001);
    check("first_gnt_id", 32'(gnt_id), 32'h0);

    // fairness rotation with immediate release
    for (int i = 0; i < 4; i++) begin
      rel = 1'b1;
      tick();
      check("rot_gap", 32'(gnt), 32'h0);
      rel = 1'b0;
      tick();
      check("rot_gnt", 32'(gnt), 32'(seq[i]));
    end
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 4'b0000;
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);

    // grant held after owner drops req
    req = 4'b0100;
    tick();
    check("hold_gnt", 32'(gnt), 32'b0100);
    check("hold_id", 32'(gnt_id), 32'd2);
    req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_noreq", 32'(gnt), 32'b0100);
    end
    rel = 1'b1;
    tick();
    check("hold_rel", 32'(gnt), 32'h0);
    rel = 1'b0;

    // wrap-around from last owner 3; rel while idle is ignored
    req = 4'b1000;
    tick();
    check("wrap_own3", 32'(gnt), 32'b1000);
    rel = 1'b1; req = 4'b0000;
    tick();
    tick();
    check("idle_rel", 32'(gnt), 32'h0);
    rel = 1'b0; req = 4'b1001;
    tick();
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    rel = 1'b1;
    tick();
    check("wrap_gap", 32'(gnt), 32'h0);
    rel = 1'b0;
    tick();
    check("wrap_gnt3", 32'(gnt), 32'b1000);

    // reset mid-grant
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 4'b0010;
    tick();
    check("pre_rst_gnt", 32'(gnt), 32'b0010);
    rstn = 1'b0;
    tick();
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    check("post_rst_id", 32'(gnt_id), 32'd1);
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 4'b0000;
    tick();

    // long grant: forced release with timeout, indefinite hold without
    req = 4'b0001;
    tick();
    check("long_first", 32'(gnt), 32'b0001);
    if (TMO_EN) begin
      for (int i = 0; i < TO - 1; i++) begin
        tick();
        check("tmo_hold", 32'(gnt), 32'b0001);
        check("tmo_low", 32'(tmo), 32'h0);
      end
      tick();
      check("tmo_drop_gnt", 32'(gnt), 32'h0);
      check("tmo_pulse", 32'(tmo), 32'h1);
      tick();
      check("tmo_regnt", 32'(gnt), 32'b0001);
      check("tmo_pulse_end", 32'(tmo), 32'h0);
      for (int i = 0; i < TO - 1; i++) tick();
      rel = 1'b1;
      tick();
      check("tmo_rel_gnt", 32'(gnt), 32'h0);
      check("tmo_rel_tmo", 32'(tmo), 32'h0);
      rel = 1'b0;
    end else begin
      for (int i = 0; i < 110; i++) begin
        tick();
        check("nohold_gnt", 32'(gnt), 32'b0001);
        check("nohold_tmo", 32'(tmo), 32'h0);
      end
      rel = 1'b1;
      tick();
      check("nohold_rel", 32'(gnt), 32'h0);
      rel = 1'b0;
    end
    req = 4'b0000;
    tick();
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
